clk_period_monitor: RTL

CLK_PERIOD_MONITOR -- requirements
Module: clk_period_monitor

---
 rtl/clk_period_monitor.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/clk_period_monitor.sv
// Measures the period of a slow clk_in (sampled as data) in clk cycles and tracks lock.
// Latency: outputs update on the clk edge that first samples clk_in high (+2 with CLKMON_SYNC_EN).
// Backpressure: none; free-running monitor. Optional macro: CLKMON_SYNC_EN adds a 2-flop synchronizer.
module clk_period_monitor #(
  parameter int CNT_W    = 16,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 2**CNT_W - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             pow2,
  output logic [4:0]       div_log2,
  output logic             locked,
  output logic             lost
);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  localparam logic [CNT_W-1:0] TO_MAX   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1    = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);

  state_t           state, state_nxt;
  logic [3:0]       match_cnt, match_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] new_period;
  logic             samp, samp_prev, rise;
  logic             load, lost_nxt, timeout_hit;
  logic             np_pow2;
  logic [4:0]       np_log2;

`ifdef CLKMON_SYNC_EN
  logic sync1, sync2;

  // Two-flop synchronizer for a clk_in from an unrelated domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= clk_in;
      sync2 <= sync1;
    end
  end

  assign samp = sync2;
`else
  assign samp = clk_in;
`endif

  // Previous sampled value for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) samp_prev <= 1'b0;
    else     samp_prev <= samp;
  end

  assign rise = samp & ~samp_prev;

  // Cycle counter: cleared by each edge, saturating so an idle input cannot wrap it.
  always_ff @(posedge clk) begin
    if (rst)                cnt <= '0;
    else if (rise)          cnt <= '0;
    else if (cnt != TO_MAX) cnt <= cnt + CNT_W'(1);
  end

  // Outside IDLE cnt never exceeds TIMEOUT-1, so cnt+1 always fits.
  assign new_period  = cnt + CNT_W'(1);
  // Fires on the cycle cnt would reach TIMEOUT; a simultaneous edge takes precedence below.
  assign timeout_hit = (cnt == TO_M1);

  // Power-of-two classification of the period about to be loaded.
  always_comb begin
    np_pow2 = (new_period != '0) && ((new_period & (new_period - CNT_W'(1))) == '0);
    np_log2 = '0;
    for (int i = 0; i < CNT_W; i++) begin
      if (new_period[i]) np_log2 = 5'(i);
    end
    if (!np_pow2) np_log2 = '0;
  end

  // Next-state logic; match_cnt==0 means no earlier period exists to compare against.
  always_comb begin
    state_nxt = state;
    match_nxt = match_cnt;
    load      = 1'b0;
    lost_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = MEASURE;
          match_nxt = '0;
        end
      end
      MEASURE: begin
        if (rise) begin
          load = 1'b1;
          if (match_cnt != '0 && new_period == period) match_nxt = match_cnt + 4'd1;
          else                                         match_nxt = 4'd1;
          if (match_nxt == LOCK_TGT) state_nxt = LOCKED;
        end else if (timeout_hit) begin
          state_nxt = IDLE;
          match_nxt = '0;
        end
      end
      LOCKED: begin
        if (rise) begin
          load = 1'b1;
          if (new_period != period) begin
            state_nxt = MEASURE;
            match_nxt = 4'd1;
            lost_nxt  = 1'b1;
          end
        end else if (timeout_hit) begin
          state_nxt = IDLE;
          match_nxt = '0;
          lost_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        match_nxt = '0;
      end
    endcase
  end

  // State and match-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      match_cnt <= '0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_nxt;
    end
  end

  // Measurement outputs; period and its classification load together, and hold on timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      period       <= '0;
      pow2         <= 1'b0;
      div_log2     <= '0;
      period_valid <= 1'b0;
      lost         <= 1'b0;
    end else begin
      period_valid <= load;
      lost         <= lost_nxt;
      if (load) begin
        period   <= new_period;
        pow2     <= np_pow2;
        div_log2 <= np_log2;
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule
